// File: rtl/hello_seg_reader.sv
`default_nettype none
//==============================================================================
// hello_seg_reader: turns the async HELLO seven-segment stream into symbols and words.  Rev 1.0
//==============================================================================
module hello_seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segments,
  input  logic       decimal,
  output logic [2:0] sym_code,
  output logic       sym_valid,
  output logic       word_done,
  output logic       err,
  output logic [7:0] word_count
);

  localparam logic [6:0] c_PAT_H = 7'b1110100;
  localparam logic [6:0] c_PAT_E = 7'b1111001;
  localparam logic [6:0] c_PAT_L = 7'b0111000;
  localparam logic [6:0] c_PAT_O = 7'b0111111;

  localparam logic [2:0] c_H   = 3'd0;
  localparam logic [2:0] c_E   = 3'd1;
  localparam logic [2:0] c_L   = 3'd2;
  localparam logic [2:0] c_O   = 3'd3;
  localparam logic [2:0] c_UNK = 3'd7;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_GOT_H  = 3'd1;
  localparam logic [2:0] c_GOT_E  = 3'd2;
  localparam logic [2:0] c_GOT_L1 = 3'd3;
  localparam logic [2:0] c_GOT_L2 = 3'd4;

  localparam logic [15:0] c_STABLE = 16'(STABLE_CYCLES);

  logic [6:0]  r_seg_s1, r_seg_s2;
  logic        r_dec_s1, r_dec_s2;
  logic [7:0]  r_prev;
  logic [15:0] r_run;
  logic [15:0] r_e_len;
  logic [2:0]  r_state;
  logic [2:0]  r_sym_code;
  logic        r_sym_valid, r_word_done, r_err;
  logic [7:0]  r_word_count;

  logic [7:0]  w_sample;
  logic        w_same, w_blank, w_prev_is_e;
  logic [2:0]  w_code;
  logic [15:0] w_run_nxt;
  logic [16:0] w_thr_sum;
  logic        w_thr_sat;
  logic        w_acc_norm, w_acc_l2, w_acc;
  logic [2:0]  w_state_nxt, w_recover;
  logic        w_err, w_done;

  always_comb begin
    w_code = c_UNK;
    case (r_seg_s2)
      c_PAT_H: w_code = c_H;
      c_PAT_E: w_code = c_E;
      c_PAT_L: w_code = c_L;
      c_PAT_O: w_code = c_O;
      default: w_code = c_UNK;
    endcase
  end

  assign w_sample    = {r_dec_s2, r_seg_s2};
  assign w_same      = (w_sample == r_prev);
  assign w_blank     = !r_dec_s2 || (r_seg_s2 == 7'b0000000);
  assign w_prev_is_e = r_prev[7] && (r_prev[6:0] == c_PAT_E);
  assign w_run_nxt   = !w_same ? 16'd1 : ((r_run == 16'hFFFF) ? r_run : r_run + 16'd1);

  // Second L is timed at 1.5x the E duration; an overflowing threshold disables it.
  assign w_thr_sum  = {1'b0, r_e_len} + {2'b00, r_e_len[15:1]};
  assign w_thr_sat  = w_thr_sum[16];
  assign w_acc_norm = !w_blank && (w_run_nxt == c_STABLE);
  assign w_acc_l2   = (r_state == c_GOT_L1) && w_same && !w_blank && (w_code == c_L) &&
                      !w_thr_sat && (w_run_nxt == w_thr_sum[15:0]) && !w_acc_norm;
  assign w_acc      = w_acc_norm || w_acc_l2;
  assign w_recover  = (w_code == c_H) ? c_GOT_H : c_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_dec_s1 <= 1'b0;
      r_dec_s2 <= 1'b0;
      r_prev   <= '0;
      r_run    <= '0;
      r_e_len  <= '0;
    end else begin
      r_seg_s1 <= segments;
      r_seg_s2 <= r_seg_s1;
      r_dec_s1 <= decimal;
      r_dec_s2 <= r_dec_s1;
      r_prev   <= w_sample;
      r_run    <= w_run_nxt;
      if (!w_same && w_prev_is_e) r_e_len <= r_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        c_IDLE:   w_state_nxt = w_recover;
        c_GOT_H:  w_state_nxt = (w_code == c_E) ? c_GOT_E : w_recover;
        c_GOT_E:  w_state_nxt = (w_code == c_L) ? c_GOT_L1 : w_recover;
        c_GOT_L1: w_state_nxt = w_acc_l2 ? c_GOT_L2 : w_recover;
        c_GOT_L2: w_state_nxt = (w_code == c_O) ? c_IDLE : w_recover;
        default:  w_state_nxt = c_IDLE;
      endcase
    end
  end

  // A non-H symbol while idle is simply ignored rather than flagged.
  always_comb begin
    w_err  = 1'b0;
    w_done = 1'b0;
    if (w_acc) begin
      case (r_state)
        c_GOT_H:  w_err = (w_code != c_E);
        c_GOT_E:  w_err = (w_code != c_L);
        c_GOT_L1: w_err = !w_acc_l2;
        c_GOT_L2: begin
          w_done = (w_code == c_O);
          w_err  = (w_code != c_O);
        end
        default:  w_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_code   <= '0;
      r_sym_valid  <= 1'b0;
      r_word_done  <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_sym_valid <= w_acc;
      r_word_done <= w_done;
      r_err       <= w_err;
      if (w_acc) r_sym_code <= w_code;
      if (w_done && (r_word_count != 8'hFF)) r_word_count <= r_word_count + 8'd1;
    end
  end

  assign sym_code   = r_sym_code;
  assign sym_valid  = r_sym_valid;
  assign word_done  = r_word_done;
  assign err        = r_err;
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_hello_seg_reader.sv
`default_nettype none
//==============================================================================
// tb_hello_seg_reader: scoreboard bench for hello_seg_reader.  Rev 1.0
//==============================================================================
module tb_hello_seg_reader;

  localparam logic [6:0] P_H = 7'b1110100;
  localparam logic [6:0] P_E = 7'b1111001;
  localparam logic [6:0] P_L = 7'b0111000;
  localparam logic [6:0] P_O = 7'b0111111;
  localparam logic [6:0] P_X = 7'b1010101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] segments = '0;
  logic       decimal = 1'b0;
  logic [2:0] sym_code;
  logic       sym_valid, word_done, err;
  logic [7:0] word_count;

  int total = 0;
  int bad = 0;
  logic [4:0] sb_q[$];

  hello_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .segments   (segments),
    .decimal    (decimal),
    .sym_code   (sym_code),
    .sym_valid  (sym_valid),
    .word_done  (word_done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected event: {code, word_done, err}
  task automatic push(input logic [2:0] code, input logic done, input logic e);
    sb_q.push_back({code, done, e});
  endtask

  task automatic hold(input logic [6:0] seg, input logic dec, input int n);
    segments = seg;
    decimal  = dec;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word();
    push(3'd0, 1'b0, 1'b0);
    push(3'd1, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b0);
    hold(P_H, 1'b1, 20);
    hold(P_E, 1'b1, 20);
    hold(P_L, 1'b1, 40);
    hold(P_O, 1'b1, 20);
  endtask

  always @(negedge clk) begin
    if (rst_n && (sym_valid || err || word_done)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {29'b0, sym_valid, err, word_done}, 32'd0);
      end else begin
        logic [4:0] e_exp;
        e_exp = sb_q.pop_front();
        chk("sb_event", {26'b0, sym_valid, sym_code, word_done, err}, {26'b0, 1'b1, e_exp});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sym_code", sym_code, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full HELLO with first-acceptance latency check
    push(3'd0, 1'b0, 1'b0);
    push(3'd1, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b0);
    segments = P_H;
    decimal  = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("h_latency_early", sym_valid, 0);
    @(posedge clk);
    #1 chk("h_latency", sym_valid, 1);
    chk("h_code", sym_code, 0);
    repeat (15) @(negedge clk);
    hold(P_E, 1'b1, 20);
    hold(P_L, 1'b1, 40);
    hold(P_O, 1'b1, 20);
    hold(7'd0, 1'b0, 10);
    chk("hello_word_count", word_count, 1);

    // Short H then blank: no acceptance, FSM still idle (L gives no err)
    hold(P_H, 1'b1, 3);
    hold(7'd0, 1'b0, 10);
    push(3'd2, 1'b0, 1'b0);
    hold(P_L, 1'b1, 20);
    hold(7'd0, 1'b0, 10);

    // H,E,L then O: O flagged as error
    push(3'd0, 1'b0, 1'b0);
    push(3'd1, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0);
    push(3'd3, 1'b0, 1'b1);
    hold(P_H, 1'b1, 20);
    hold(P_E, 1'b1, 20);
    hold(P_L, 1'b1, 20);
    hold(P_O, 1'b1, 20);
    hold(7'd0, 1'b0, 10);
    chk("oos_word_count", word_count, 1);
    push(3'd1, 1'b0, 1'b0);
    hold(P_E, 1'b1, 20);
    hold(7'd0, 1'b0, 10);

    // Unknown pattern in GOT_H: code 7 with err, back to IDLE
    push(3'd0, 1'b0, 1'b0);
    push(3'd7, 1'b0, 1'b1);
    hold(P_H, 1'b1, 20);
    hold(P_X, 1'b1, 10);
    chk("unk_code", sym_code, 7);
    push(3'd2, 1'b0, 1'b0);
    hold(P_L, 1'b1, 20);
    hold(7'd0, 1'b0, 10);

    // Reset during the E run
    push(3'd0, 1'b0, 1'b0);
    push(3'd1, 1'b0, 1'b0);
    hold(P_H, 1'b1, 20);
    hold(P_E, 1'b1, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_sym_code", sym_code, 0);
    chk("midrst_sym_valid", sym_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_word_done", word_done, 0);
    chk("midrst_word_count", word_count, 0);
    segments = '0;
    decimal  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(7'd0, 1'b0, 5);
    send_word();
    chk("post_rst_word_count", word_count, 1);

    // Saturation of word_count
    for (int i = 1; i <= 260; i++) begin
      send_word();
      if (i == 253) chk("wc_254", word_count, 254);
      if (i == 254) chk("wc_255", word_count, 255);
    end
    chk("wc_saturated", word_count, 255);

    hold(7'd0, 1'b0, 10);
    chk("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hello_seg_reader.md
HELLO_SEG_READER -- requirements
Module: hello_seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a symbol; legal range 2..255.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active low.
REQ-004 segments  input  7  seven-segment pattern from the HELLO display driver; asynchronous to clk.
REQ-005 decimal  input  1  display-enable/flash line from the same driver; asynchronous to clk.
REQ-006 sym_code  output  3  last accepted symbol: 0=H, 1=E, 2=L, 3=O, 7=unknown.
REQ-007 sym_valid  output  1  one-cycle pulse on each symbol acceptance.
REQ-008 word_done  output  1  one-cycle pulse when H,E,L,L,O completes in order.
REQ-009 err  output  1  one-cycle pulse on an out-of-order or unknown symbol.
REQ-010 word_count  output  8  count of completed words, saturating.

Function
REQ-011 segments and decimal SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 A synchronized sample with decimal=0 or segments=7'b0000000 SHALL be blank; blanks never produce acceptances.
REQ-013 Decode: 7'b1110100->0 (H), 7'b1111001->1 (E), 7'b0111000->2 (L), 7'b0111111->3 (O); any other non-blank pattern->7.
REQ-014 A 16-bit run counter SHALL load 1 when the synchronized sample differs from the previous one, otherwise increment, saturating at 16'hFFFF.
REQ-015 A non-blank run SHALL be accepted once, in the cycle its run count equals STABLE_CYCLES; sym_valid and sym_code are registered, so sym_valid pulses STABLE_CYCLES+2 cycles after the input change.
REQ-016 sym_code SHALL hold its value between acceptances.
REQ-017 When a run decoded as E ends, its final run count SHALL be latched into e_len (16 bits).
REQ-018 In state GOT_L1, while the same L run continues, the cycle its run count equals e_len + (e_len>>1) (computed saturating at 16'hFFFF) SHALL produce a second L acceptance (sym_valid, sym_code=2); at most one per run; no second acceptance if the threshold saturates.
REQ-019 FSM states: IDLE, GOT_H, GOT_E, GOT_L1, GOT_L2.
REQ-020 Transitions on acceptance: IDLE+H->GOT_H; GOT_H+E->GOT_E; GOT_E+L->GOT_L1; GOT_L1+L (REQ-018)->GOT_L2; GOT_L2+O->IDLE with word_done pulse.
REQ-021 Any other accepted symbol (including 7, or a new L run in GOT_L1) SHALL pulse err and go to GOT_H if the symbol is H, else IDLE.
REQ-022 IDLE with a non-H symbol SHALL stay IDLE without err.
REQ-023 Blanks SHALL NOT change FSM state.
REQ-024 word_done, err and sym_valid for the same acceptance SHALL assert in the same cycle; word_done and err are mutually exclusive.
REQ-025 word_count SHALL increment on word_done and saturate at 255.

Reset
REQ-026 While rst_n=0: synchronizers and the run counter clear to 0; FSM goes to IDLE; e_len=0; sym_code=0; sym_valid, word_done, err=0; word_count=0.
REQ-027 A reset in mid-word SHALL discard the partial word with no err or word_done pulse; after rst_n rises, decoding restarts from IDLE on the next full run.

Verification
REQ-028 STABLE_CYCLES=4. Drive decimal=1 and H,E,L,L,O, 20 cycles each with no blanks -> five sym_valid pulses with codes 0,1,2,2,3; the first pulse 6 cycles after H is applied; second L pulse 30 cycles into the L run; one word_done; word_count=1; err never.
REQ-029 H pattern held for 3 cycles, then blank -> no sym_valid, FSM stays IDLE.
REQ-030 H,E,L (20 cycles each), then O -> err pulse with the O acceptance, FSM IDLE, word_count unchanged.
REQ-031 7'b1010101 held 10 cycles while in GOT_H -> sym_valid with sym_code=7, err pulse, FSM IDLE.
REQ-032 rst_n pulsed low during the E run of a word -> all outputs 0 immediately; a subsequent full HELLO yields word_count=1.
REQ-033 Send 260 complete words -> word_count stays at 255 while word_done still pulses.
